// File: rtl/aes_pkg.sv
// Shared types and defaults for the iterative AES-128 inverse-cipher control slice.
package aes_pkg;

  localparam int NR_DEFAULT    = 10;
  localparam int IDX_W_DEFAULT = 4;

  typedef logic [IDX_W_DEFAULT-1:0] rk_idx_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_LOAD   = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } aes_seq_state_t;

endpackage

// File: rtl/aes_round_ctr.sv
// Loadable up/down round counter with a terminal-value flag; saturates at the terminal value
// so it can never wrap past the end of a key schedule or round sequence.
module aes_round_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         up,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] count_q, count_d;

  assign count   = count_q;
  assign at_term = (count_q == term_val);

  // NOTE: next-state logic assigns a default first, so no path leaves count_d unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step && !at_term) begin
      count_d = up ? count_q + W'(1) : count_q - W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_dec_sequencer.sv
// Control FSM for the one-round-per-cycle AES-128 inverse cipher: optional key expansion,
// state load, NR inverse rounds and valid/ready result hand-off. Outputs decode from registered state.
module aes_dec_sequencer
  import aes_pkg::*;
#(
  parameter int NR    = NR_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             key_new,
  input  logic             abort,
  output logic             ke_en,
  output logic [IDX_W-1:0] ke_idx,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic             dp_last,
  output logic [IDX_W-1:0] rk_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] NR_IDX  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] NR_M1   = IDX_W'(NR - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  aes_seq_state_t   state_q, state_d;
  logic             key_cached_q, key_cached_d;

  logic             ctr_load, ctr_step, ctr_up, ctr_at_term;
  logic [IDX_W-1:0] ctr_load_val, ctr_term, ctr_count;

  aes_round_ctr #(.W(IDX_W)) u_round_ctr (
    .clk      (clock),
    .rst_n    (reset_n),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .step     (ctr_step),
    .up       (ctr_up),
    .term_val (ctr_term),
    .count    (ctr_count),
    .at_term  (ctr_at_term)
  );

  always_comb begin
    state_d      = state_q;
    key_cached_d = key_cached_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_step     = 1'b0;
    ctr_up       = 1'b0;
    ctr_term     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          if (key_new || !key_cached_q) begin
            state_d      = S_KEYEXP;
            ctr_load     = 1'b1;
            ctr_load_val = IDX_ONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_KEYEXP: begin
        ctr_up   = 1'b1;
        ctr_term = NR_IDX;
        if (ctr_at_term) begin
          key_cached_d = 1'b1;
          state_d      = S_LOAD;
        end else begin
          ctr_step = 1'b1;
        end
      end
      S_LOAD: begin
        state_d      = S_ROUND;
        ctr_load     = 1'b1;
        ctr_load_val = NR_M1;
      end
      S_ROUND: begin
        if (ctr_at_term) begin
          state_d = S_DONE;
        end else begin
          ctr_step = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        ctr_load = 1'b1;
      end
    endcase

    // Abort overrides everything outside IDLE; a half-built key schedule is no longer trusted.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      ctr_load     = 1'b1;
      ctr_load_val = '0;
      ctr_step     = 1'b0;
      if (state_q == S_KEYEXP) key_cached_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      key_cached_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_cached_q <= key_cached_d;
    end
  end

  // start_ready is gated by reset_n so it stays low for the whole reset window.
  always_comb begin
    start_ready = reset_n && (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    ke_en       = (state_q == S_KEYEXP);
    ke_idx      = (state_q == S_KEYEXP) ? ctr_count : '0;
    dp_load     = (state_q == S_LOAD);
    dp_round_en = (state_q == S_ROUND);
    dp_last     = (state_q == S_ROUND) && (ctr_count == '0);
    res_valid   = (state_q == S_DONE);
    rk_idx      = '0;
    if (state_q == S_LOAD)  rk_idx = NR_IDX;
    if (state_q == S_ROUND) rk_idx = ctr_count;
  end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Scoreboard bench: a small AES inverse-cipher datapath model follows the sequencer's control
// outputs; a monitor checks each hand-off against expectations queued by the stimulus.
module tb_aes_dec_sequencer;
  import aes_pkg::*;

  localparam int NR = NR_DEFAULT;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    int           ke_steps;
    int           latency;
    logic [127:0] pt;
  } exp_t;

  logic          clock, reset_n;
  logic          start_valid, start_ready, key_new, abort;
  logic          ke_en, dp_load, dp_round_en, dp_last, res_valid, res_ready, busy;
  rk_idx_t       ke_idx, rk_idx;
  logic [14:0]   outs;

  assign outs = {start_ready, ke_en, ke_idx, dp_load, dp_round_en, dp_last, rk_idx, res_valid, busy};

  aes_dec_sequencer #(.NR(NR), .IDX_W(IDX_W_DEFAULT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_new     (key_new),
    .abort       (abort),
    .ke_en       (ke_en),
    .ke_idx      (ke_idx),
    .dp_load     (dp_load),
    .dp_round_en (dp_round_en),
    .dp_last     (dp_last),
    .rk_idx      (rk_idx),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   total, passed, idx_err;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rk [0:15];
  logic [127:0] st;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] expand_step(input logic [127:0] prev, input int i);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc = 8'h01;
    for (int j = 1; j < i; j++) rc = xtime(rc);
    {w0, w1, w2, w3} = prev;
    t = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        o[row + 4*col] = isbox_t[b[row + 4*((col - row + 4) % 4)]];
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    res = res ^ k;
    if (!last) begin
      for (int col = 0; col < 4; col++) begin
        a0 = res[127-32*col -: 8];
        a1 = res[119-32*col -: 8];
        a2 = res[111-32*col -: 8];
        a3 = res[103-32*col -: 8];
        res[127-32*col -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
        res[119-32*col -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
        res[111-32*col -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
        res[103-32*col -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
    end
    return res;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  // Datapath model driven purely by the sequencer's control outputs.
  always @(negedge clock) begin
    if (ke_en && ke_idx != 0) rk[int'(ke_idx)] = expand_step(rk[int'(ke_idx) - 1], int'(ke_idx));
    if (dp_load)              st = CT ^ rk[int'(rk_idx)];
    if (dp_round_en)          st = inv_round(st, rk[int'(rk_idx)], dp_last);
  end

  // ---------------- monitor ----------------
  int      cyc, ke_cnt, rnd_cnt, load_cnt, order_err, lat;
  bit      seen_v;
  rk_idx_t exp_rk;

  always @(negedge clock) begin
    exp_t e;
    if (start_valid && start_ready) begin
      cyc = -1; ke_cnt = 0; rnd_cnt = 0; load_cnt = 0; order_err = 0; lat = -1; seen_v = 0;
    end else begin
      cyc++;
    end
    if (ke_en) begin
      if (int'(ke_idx) != ke_cnt + 1) order_err++;
      ke_cnt++;
    end
    if (dp_load) begin
      if (int'(rk_idx) != NR) order_err++;
      load_cnt++;
    end
    if (dp_round_en) begin
      exp_rk = rk_idx_t'(NR - 1 - rnd_cnt);
      if (rk_idx != exp_rk) order_err++;
      if (dp_last != (rk_idx == 0)) order_err++;
      rnd_cnt++;
    end
    if (!ke_en && ke_idx != 0) idx_err++;
    if (!dp_load && !dp_round_en && rk_idx != 0) idx_err++;
    if (res_valid && !seen_v) begin
      lat    = cyc;
      seen_v = 1'b1;
    end
    if (res_valid && res_ready) begin
      check("result_queued", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("plaintext",      st,                e.pt);
        check("latency",        128'(lat),         128'(e.latency));
        check("ke_steps",       128'(ke_cnt),      128'(e.ke_steps));
        check("round_count",    128'(rnd_cnt),     128'(NR));
        check("load_count",     128'(load_cnt),    128'(1));
        check("index_order",    128'(order_err),   128'(0));
        check("no_start_in_done", 128'(start_ready), 128'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int ks, input int l);
    exp_t e;
    e.ke_steps = ks;
    e.latency  = l;
    e.pt       = PT;
    exp_q.push_back(e);
  endtask

  task automatic start_txn(input logic kn, input logic ab);
    @(posedge clock); #1;
    start_valid = 1'b1; key_new = kn; abort = ab;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (start_ready) break;
    end
    @(posedge clock); #1;
    start_valid = 1'b0; key_new = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    check(name, 128'(exp_q.size()), 128'(0));
    @(posedge clock); #1;
    check("idle_after_handoff", 128'({start_ready, res_valid}), 128'(2'b10));
  endtask

  initial begin
    total = 0; passed = 0; idx_err = 0;
    build_sbox();
    rk[0] = KEY;
    st    = '0;
    reset_n = 1'b0; start_valid = 1'b0; key_new = 1'b0; abort = 1'b0; res_ready = 1'b0;

    #3 check("reset_outputs", 128'(outs), 128'(0));
    repeat (3) @(negedge clock);
    check("reset_outputs_held", 128'(outs), 128'(0));
    reset_n = 1'b1;
    #1 check("release_idle", 128'({start_ready, busy}), 128'(2'b10));

    // First block: fresh key, full expansion.
    res_ready = 1'b1;
    push(10, 21);
    start_txn(1'b1, 1'b0);
    wait_done("tx_first_drain");

    // Cached key; abort asserted together with start in IDLE must not block the start.
    push(0, 11);
    start_txn(1'b0, 1'b1);
    wait_done("tx_cached_drain");

    // Consumer stalls in DONE.
    res_ready = 1'b0;
    push(0, 11);
    start_txn(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (res_valid) break;
    end
    check("stall_reached_done", 128'(res_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_hold", 128'({res_valid, start_ready, ke_en, dp_load, dp_round_en}),
            128'(5'b10000));
    end
    @(posedge clock); #1 res_ready = 1'b1;
    wait_done("tx_stall_drain");

    // Abort during key expansion invalidates the cached key.
    start_txn(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ke_en && ke_idx == 4) break;
    end
    check("saw_ke_idx4", 128'(ke_en && ke_idx == 4), 128'(1));
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    check("abort_keyexp_idle", 128'({busy, ke_en, ke_idx, start_ready}), 128'(7'b0000001));
    push(10, 21);
    start_txn(1'b0, 1'b0);
    wait_done("tx_after_ke_abort_drain");

    // Abort mid-round keeps the cached key.
    start_txn(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dp_round_en && rk_idx == 5) break;
    end
    check("saw_rk_idx5", 128'(dp_round_en && rk_idx == 5), 128'(1));
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    check("abort_round_idle", 128'({busy, dp_round_en, rk_idx, start_ready}), 128'(7'b0000001));
    push(0, 11);
    start_txn(1'b0, 1'b0);
    wait_done("tx_after_round_abort_drain");

    // Asynchronous reset between edges in the middle of ROUND.
    start_txn(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dp_round_en && rk_idx == 6) break;
    end
    check("saw_rk_idx6", 128'(dp_round_en && rk_idx == 6), 128'(1));
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", 128'(outs), 128'(0));
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("rerelease_idle", 128'({start_ready, busy}), 128'(2'b10));
    push(10, 21);
    start_txn(1'b0, 1'b0);
    wait_done("tx_after_reset_drain");

    check("idx_outside_zero", 128'(idx_err), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
